// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: run/stop state encoding and default timing constants.
package stopwatch_pkg;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_CLK_HZ          = 50000000;
    localparam int DEFAULT_TICK_HZ         = 1;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/key_debounce.sv
// Synchronises an active-low key and emits a single-cycle pulse on each accepted press.
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(DEBOUNCE_CYCLES);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    // The counter runs while the synchronised level disagrees with the accepted one;
    // any return to the accepted level restarts the qualification window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LIMIT) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
                r_press  <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign press = r_press;

endmodule

// File: rtl/stopwatch_n.sv
// Start/stop, clear and direction-controlled stopwatch counting at TICK_HZ with wrap at MAX_COUNT.
module stopwatch_n
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ          = DEFAULT_CLK_HZ,
    parameter int TICK_HZ         = DEFAULT_TICK_HZ,
    parameter int WIDTH           = 8,
    parameter int MAX_COUNT       = 2**WIDTH - 1,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key0,
    input  logic             key1,
    input  logic             key2,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             dir_down,
    output logic             wrap
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] COUNT_LAST = WIDTH'(MAX_COUNT);

    logic             w_start;
    logic             w_clear;
    logic             w_toggle;
    logic             w_tick;
    logic [WIDTH-1:0] w_count_next;
    logic             w_wrap_next;
    state_t           w_state_next;

    state_t           r_state;
    logic [PW-1:0]    r_presc;
    logic [WIDTH-1:0] r_count;
    logic             r_dir;
    logic             r_wrap;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
        .clk(clk), .rst(rst), .key_n(key0), .press(w_start)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
        .clk(clk), .rst(rst), .key_n(key1), .press(w_clear)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key2 (
        .clk(clk), .rst(rst), .key_n(key2), .press(w_toggle)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= STOP;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_start) begin
            w_state_next = (r_state == STOP) ? RUN : STOP;
        end
    end

    assign w_tick = (r_state == RUN) && (r_presc == PRESC_LAST);

    // The tick steps in the direction held before any same-cycle toggle.
    always_comb begin
        w_count_next = r_count;
        w_wrap_next  = 1'b0;
        if (!r_dir) begin
            if (r_count == COUNT_LAST) begin
                w_count_next = '0;
                w_wrap_next  = 1'b1;
            end else begin
                w_count_next = r_count + 1'b1;
            end
        end else begin
            if (r_count == '0) begin
                w_count_next = COUNT_LAST;
                w_wrap_next  = 1'b1;
            end else begin
                w_count_next = r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_count <= '0;
            r_dir   <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_toggle) begin
                r_dir <= ~r_dir;
            end
            if (w_clear) begin
                r_presc <= '0;
                r_count <= '0;
            end else begin
                if (r_state == RUN) begin
                    r_presc <= w_tick ? '0 : r_presc + 1'b1;
                end
                if (w_tick) begin
                    r_count <= w_count_next;
                    r_wrap  <= w_wrap_next;
                end
            end
        end
    end

    assign count    = r_count;
    assign running  = (r_state == RUN);
    assign dir_down = r_dir;
    assign wrap     = r_wrap;

endmodule
